// File: rtl/uart_tx_ctrl.sv
// Transmit-side glue between the CPU store path and uart_tx: a byte FIFO that is
// drained by a launch/handshake FSM with a timeout on the busy-rise acknowledge.
module uart_tx_ctrl #(
  parameter int DEPTH   = 8,
  parameter int BUSY_TO = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   ovf_clr,
  input  logic                   uart_busy,
  output logic                   uart_write_en,
  output logic [7:0]             uart_data,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   tx_idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = (BUSY_TO < 2) ? 1 : $clog2(BUSY_TO);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [TW-1:0] TO_LAST  = TW'(BUSY_TO - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [TW-1:0] to_cnt;
  logic          launch;
  logic          do_push;
  logic          drop;

  assign fifo_full  = (level == LVL_FULL);
  assign fifo_empty = (level == '0);
  assign tx_idle    = fifo_empty && (state == IDLE) && !uart_busy;

  // A full FIFO still accepts a byte when the launch frees a slot in the same cycle.
  assign do_push = wr_en && (!fifo_full || launch);
  assign drop    = wr_en && fifo_full && !launch;

  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (launch) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !launch) begin
        level <= level + LW'(1);
      end else if (launch && !do_push) begin
        level <= level - LW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Launch only from IDLE, so a strobe is always separated from the previous one.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !uart_busy) begin
          launch    = 1'b1;
          state_nxt = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (uart_busy) begin
          state_nxt = WAIT_DONE;
        end else if (to_cnt == TO_LAST) begin
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!uart_busy) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Counts WAIT_BUSY cycles without an acknowledge; cleared whenever we are elsewhere.
  always_ff @(posedge clk) begin
    if (rst || state != WAIT_BUSY) begin
      to_cnt <= '0;
    end else if (!uart_busy) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      uart_write_en <= 1'b0;
      uart_data     <= 8'h00;
    end else begin
      uart_write_en <= launch;
      if (launch) begin
        uart_data <= mem[rd_ptr];
      end
    end
  end

  // A dropped byte outranks a clear arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: directed scenarios plus random traffic,
// scored against a queue-based model of the FIFO contents and an ideal uart_tx responder.
module tb_uart_tx_ctrl;

  localparam int DEPTH   = 8;
  localparam int BUSY_TO = 4;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          ovf_clr = 1'b0;
  logic          uart_busy = 1'b0;
  logic          uart_write_en;
  logic [7:0]    uart_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] level;
  logic          overflow;
  logic          tx_idle;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] q[$];
  logic [7:0] strobe_log[$];
  int         strobe_cyc[$];
  logic       exp_ovf     = 1'b0;
  logic [7:0] exp_data    = 8'h00;
  logic       prev_strobe = 1'b0;

  bit resp_on    = 1'b0;
  bit force_busy = 1'b0;
  int hold_len   = 0;
  int busy_left  = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.DEPTH(DEPTH), .BUSY_TO(BUSY_TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .ovf_clr      (ovf_clr),
    .uart_busy    (uart_busy),
    .uart_write_en(uart_write_en),
    .uart_data    (uart_data),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .level        (level),
    .overflow     (overflow),
    .tx_idle      (tx_idle)
  );

  // One clock: observe just after the edge, update the model, then answer as uart_tx would.
  task automatic step();
    logic sampled_busy;
    logic strobe;
    logic dropped;
    sampled_busy = uart_busy;
    @(posedge clk);
    #1;
    cyc++;
    strobe = (uart_write_en === 1'b1);
    if (rst) begin
      q.delete();
      exp_ovf  = 1'b0;
      exp_data = 8'h00;
      total++;
      if (strobe) begin
        bad++;
        $display("[TB] FAIL strobe_in_reset: got %b expected 0 (cycle %0d)", uart_write_en, cyc);
      end
    end else begin
      if (strobe) begin
        strobe_log.push_back(uart_data);
        strobe_cyc.push_back(cyc);
        total++;
        if (sampled_busy) begin
          bad++;
          $display("[TB] FAIL strobe_while_busy: strobe launched with uart_busy=1 (cycle %0d)", cyc);
        end
        total++;
        if (prev_strobe) begin
          bad++;
          $display("[TB] FAIL back_to_back: strobe in two consecutive cycles (cycle %0d)", cyc);
        end
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_strobe: strobe with model queue empty, data=%02h (cycle %0d)", uart_data, cyc);
        end else begin
          exp_data = q.pop_front();
        end
      end
      dropped = wr_en && (q.size() >= DEPTH);
      if (wr_en && !dropped) q.push_back(wr_data);
      if (dropped) exp_ovf = 1'b1;
      else if (ovf_clr) exp_ovf = 1'b0;
    end
    prev_strobe = strobe;

    total++;
    if (level !== LW'(q.size())) begin
      bad++;
      $display("[TB] FAIL level: got %0d expected %0d (cycle %0d)", level, q.size(), cyc);
    end
    total++;
    if (fifo_empty !== (q.size() == 0)) begin
      bad++;
      $display("[TB] FAIL fifo_empty: got %b expected %b (cycle %0d)", fifo_empty, q.size() == 0, cyc);
    end
    total++;
    if (fifo_full !== (q.size() == DEPTH)) begin
      bad++;
      $display("[TB] FAIL fifo_full: got %b expected %b (cycle %0d)", fifo_full, q.size() == DEPTH, cyc);
    end
    total++;
    if (overflow !== exp_ovf) begin
      bad++;
      $display("[TB] FAIL overflow: got %b expected %b (cycle %0d)", overflow, exp_ovf, cyc);
    end
    total++;
    if (uart_data !== exp_data) begin
      bad++;
      $display("[TB] FAIL uart_data: got %02h expected %02h (cycle %0d)", uart_data, exp_data, cyc);
    end
    if (q.size() != 0) begin
      total++;
      if (tx_idle !== 1'b0) begin
        bad++;
        $display("[TB] FAIL tx_idle_nonempty: got %b expected 0 (cycle %0d)", tx_idle, cyc);
      end
    end

    if (resp_on) begin
      if (strobe) busy_left = hold_len;
      else if (busy_left > 0) busy_left--;
    end
    uart_busy = force_busy || (busy_left > 0);
    #1;
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int k;
    k = 0;
    wr_en   = 1'b0;
    ovf_clr = 1'b0;
    while (k < bound && !(tx_idle === 1'b1 && fifo_empty === 1'b1)) begin
      step();
      k++;
    end
    total++;
    if (!(tx_idle === 1'b1 && fifo_empty === 1'b1)) begin
      bad++;
      $display("[TB] FAIL %s_drain: tx_idle=%b fifo_empty=%b, expected both 1 within %0d cycles", tag, tx_idle, fifo_empty, bound);
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst = 1'b1; wr_en = 1'b1; wr_data = 8'hAA;
    step();
    step();
    rst = 1'b0; wr_en = 1'b0;
    total++;
    if (level !== '0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_fifo: got level=%0d empty=%b full=%b expected 0/1/0", level, fifo_empty, fifo_full);
    end
    total++;
    if (tx_idle !== 1'b1 || uart_write_en !== 1'b0 || uart_data !== 8'h00 || overflow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got idle=%b we=%b data=%02h ovf=%b expected 1/0/00/0", tx_idle, uart_write_en, uart_data, overflow);
    end
    step();
  endtask

  task automatic test_single_byte();
    $display("[TB] test_single_byte");
    resp_on = 1'b1; hold_len = 3;
    wr_en = 1'b1; wr_data = 8'h41;
    step();
    wr_en = 1'b0;
    total++;
    if (level !== LW'(1) || uart_write_en !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_push: got level=%0d we=%b expected 1/0", level, uart_write_en);
    end
    step();
    total++;
    if (uart_write_en !== 1'b1 || uart_data !== 8'h41) begin
      bad++;
      $display("[TB] FAIL single_strobe: got we=%b data=%02h expected 1/41", uart_write_en, uart_data);
    end
    total++;
    if (level !== '0) begin
      bad++;
      $display("[TB] FAIL single_level: got %0d expected 0", level);
    end
    step();
    total++;
    if (uart_write_en !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_pulse_width: got we=%b expected 0", uart_write_en);
    end
    wait_idle(30, "single");
  endtask

  task automatic test_burst();
    int base;
    logic [7:0] e;
    $display("[TB] test_burst");
    resp_on = 1'b1; hold_len = 10;
    base = strobe_log.size();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    for (int k = 0; k < 400 && (strobe_log.size() - base) < 8; k++) step();
    total++;
    if (strobe_log.size() - base != 8) begin
      bad++;
      $display("[TB] FAIL burst_count: got %0d strobes expected 8", strobe_log.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        e = 8'h10 + 8'(i);
        total++;
        if (strobe_log[base + i] !== e) begin
          bad++;
          $display("[TB] FAIL burst_order[%0d]: got %02h expected %02h", i, strobe_log[base + i], e);
        end
      end
    end
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL burst_overflow: got %b expected 0", overflow);
    end
    wait_idle(60, "burst");
  endtask

  task automatic test_overflow();
    $display("[TB] test_overflow");
    resp_on = 1'b0; busy_left = 0; force_busy = 1'b1; uart_busy = 1'b1;
    step();
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom);
      step();
      if (i == 7) begin
        total++;
        if (fifo_full !== 1'b1 || level !== LW'(8) || overflow !== 1'b0) begin
          bad++;
          $display("[TB] FAIL ovf_full: got full=%b level=%0d ovf=%b expected 1/8/0", fifo_full, level, overflow);
        end
      end
    end
    total++;
    if (overflow !== 1'b1 || level !== LW'(8)) begin
      bad++;
      $display("[TB] FAIL ovf_drop: got ovf=%b level=%0d expected 1/8", overflow, level);
    end
    wr_en = 1'b1; ovf_clr = 1'b1; wr_data = 8'h99;
    step();
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ovf_set_wins: got %b expected 1", overflow);
    end
    wr_en = 1'b0;
    step();
    ovf_clr = 1'b0;
    total++;
    if (overflow !== 1'b0 || level !== LW'(8)) begin
      bad++;
      $display("[TB] FAIL ovf_clear: got ovf=%b level=%0d expected 0/8", overflow, level);
    end
  endtask

  task automatic test_full_pop();
    $display("[TB] test_full_pop");
    force_busy = 1'b0; uart_busy = 1'b0; resp_on = 1'b1; hold_len = 10; busy_left = 0;
    wr_en = 1'b1; wr_data = 8'hC3;
    step();
    wr_en = 1'b0;
    total++;
    if (uart_write_en !== 1'b1 || level !== LW'(8) || fifo_full !== 1'b1 || overflow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL full_pop: got we=%b level=%0d full=%b ovf=%b expected 1/8/1/0", uart_write_en, level, fifo_full, overflow);
    end
    wait_idle(300, "full_pop");
  endtask

  task automatic test_timeout();
    int base;
    int push_cyc;
    $display("[TB] test_timeout");
    resp_on = 1'b0; force_busy = 1'b0; busy_left = 0; uart_busy = 1'b0;
    base = strobe_log.size();
    wr_en = 1'b1; wr_data = 8'h3A;
    step();
    push_cyc = cyc;
    wr_data = 8'h3B;
    step();
    wr_en = 1'b0;
    for (int k = 0; k < 40 && (strobe_log.size() - base) < 2; k++) step();
    total++;
    if (strobe_log.size() - base < 2) begin
      bad++;
      $display("[TB] FAIL timeout_count: got %0d strobes expected 2", strobe_log.size() - base);
    end else begin
      total++;
      if (strobe_cyc[base] != push_cyc + 1) begin
        bad++;
        $display("[TB] FAIL timeout_first: got cycle %0d expected %0d", strobe_cyc[base], push_cyc + 1);
      end
      total++;
      if (strobe_cyc[base + 1] - strobe_cyc[base] != BUSY_TO + 1) begin
        bad++;
        $display("[TB] FAIL timeout_gap: got %0d cycles expected %0d", strobe_cyc[base + 1] - strobe_cyc[base], BUSY_TO + 1);
      end
    end
    wait_idle(20, "timeout");
  endtask

  task automatic test_reset_mid();
    int base;
    $display("[TB] test_reset_mid");
    resp_on = 1'b1; hold_len = 10;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom);
      step();
    end
    total++;
    if (level !== LW'(5) || uart_busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_setup: got level=%0d busy=%b expected 5/1", level, uart_busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0; wr_en = 1'b0;
    total++;
    if (level !== '0 || fifo_empty !== 1'b1 || uart_write_en !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_reset: got level=%0d empty=%b we=%b expected 0/1/0", level, fifo_empty, uart_write_en);
    end
    base = strobe_log.size();
    for (int k = 0; k < 12; k++) step();
    total++;
    if (strobe_log.size() != base) begin
      bad++;
      $display("[TB] FAIL mid_no_strobe: got %0d strobes expected 0", strobe_log.size() - base);
    end
    wr_en = 1'b1; wr_data = 8'h55;
    step();
    wr_en = 1'b0;
    for (int k = 0; k < 20 && strobe_log.size() == base; k++) step();
    total++;
    if (strobe_log.size() == base || strobe_log[base] !== 8'h55) begin
      bad++;
      $display("[TB] FAIL mid_resume: got %0d strobes, first=%02h expected 55", strobe_log.size() - base,
               (strobe_log.size() > base) ? strobe_log[base] : 8'h00);
    end
    wait_idle(40, "reset_mid");
  endtask

  task automatic test_random();
    $display("[TB] test_random");
    resp_on = 1'b1;
    for (int k = 0; k < 600; k++) begin
      wr_en    = ($urandom_range(0, 99) < 40);
      wr_data  = 8'($urandom);
      ovf_clr  = ($urandom_range(0, 19) == 0);
      hold_len = $urandom_range(0, 8);
      step();
    end
    wait_idle(400, "random");
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_overflow();
    test_full_pop();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries; legal values are powers of two from 2 to 64.
REQ-002 SHALL have parameter BUSY_TO, default 4, meaning the maximum cycles to wait for uart_busy to rise after a launch.
REQ-003 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port wr_en  input  1  CPU store to the UART data address, already decoded by the MMU.
REQ-006 SHALL have port wr_data  input  8  byte to transmit, from CPU store data [7:0].
REQ-007 SHALL have port ovf_clr  input  1  clears the sticky overflow flag.
REQ-008 SHALL have port uart_busy  input  1  busy flag from uart_tx.
REQ-009 SHALL have port uart_write_en  output  1  one-cycle launch strobe to uart_tx.
REQ-010 SHALL have port uart_data  output  8  byte presented to uart_tx.
REQ-011 SHALL have port fifo_full  output  1  asserted when level == DEPTH.
REQ-012 SHALL have port fifo_empty  output  1  asserted when level == 0.
REQ-013 SHALL have port level  output  log2(DEPTH)+1  current FIFO occupancy.
REQ-014 SHALL have port overflow  output  1  sticky flag, set when a byte is dropped.
REQ-015 SHALL have port tx_idle  output  1  asserted when the FIFO is empty, the FSM is in IDLE and uart_busy == 0.

Function
REQ-016 SHALL implement a circular FIFO with read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a separate level counter.
REQ-017 SHALL push wr_data on a cycle with wr_en=1 when not full, or when full and a pop occurs in the same cycle.
REQ-018 SHALL drop wr_data and set overflow on a cycle with wr_en=1, full, and no pop; pointers and level are unchanged.
REQ-019 SHALL, on a simultaneous push and pop, leave level unchanged and advance both pointers.
REQ-020 SHALL register all outputs except fifo_full, fifo_empty, level and tx_idle, which are decoded from registered state.
REQ-021 SHALL implement FSM states IDLE, WAIT_BUSY and WAIT_DONE.
REQ-022 SHALL, in IDLE with FIFO not empty and uart_busy=0, pop the head, load uart_data with the popped byte, pulse uart_write_en=1 for exactly one cycle, and enter WAIT_BUSY.
REQ-023 SHALL, in WAIT_BUSY, enter WAIT_DONE when uart_busy=1, or return to IDLE after BUSY_TO cycles without uart_busy=1 (timeout).
REQ-024 SHALL, in WAIT_DONE, return to IDLE on the first cycle with uart_busy=0.
REQ-025 SHALL give uart_write_en a latency of one cycle from a push into an empty FIFO in IDLE with uart_busy=0 (push at edge N, strobe high during cycle N+1).
REQ-026 SHALL start the next launch no earlier than one cycle after IDLE is re-entered, so strobes are never issued back-to-back.
REQ-027 SHALL hold uart_data stable from the strobe cycle until the next pop.
REQ-028 SHALL, when ovf_clr and an overflow event occur in the same cycle, leave overflow at 1 (set wins).
REQ-029 SHALL never issue uart_write_en while uart_busy=1 or while the FSM is outside IDLE.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, clear the pointers, level, overflow and uart_data (0x00), set uart_write_en=0, and set the FSM to IDLE.
REQ-031 SHALL, on reset mid-transmission, discard all queued bytes, issue no further strobes, and ignore uart_busy until the FSM is back in IDLE.
REQ-032 SHALL ignore wr_en during any cycle with rst=1.
REQ-033 SHALL drive fifo_empty=1, fifo_full=0, level=0 and tx_idle=1 (if uart_busy=0) on the first cycle after rst is released.

Verification
REQ-034 SHALL pass single byte: write 0x41 with the FIFO empty and uart_busy=0 -> uart_write_en pulses one cycle later with uart_data=0x41, and level returns to 0.
REQ-035 SHALL pass burst/order: write 0x10..0x17 on consecutive cycles while the model holds busy for 10 cycles per byte -> 8 strobes in order 0x10..0x17, overflow=0.
REQ-036 SHALL pass overflow: hold uart_busy=1 and write 9 bytes (DEPTH=8) -> fifo_full=1 after the 8th write, 9th byte dropped, overflow=1; assert ovf_clr -> overflow=0.
REQ-037 SHALL pass full with simultaneous pop: FIFO full, uart_busy falls, and wr_en=1 on the pop cycle -> byte accepted, level stays 8, overflow=0.
REQ-038 SHALL pass busy timeout: the model never raises busy -> FSM returns to IDLE after 4 cycles in WAIT_BUSY and the next byte launches.
REQ-039 SHALL pass reset mid-operation: assert rst with 5 bytes queued and a transfer active -> level=0, no strobe after release, and a new write 0x55 transmits normally.
